// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
//   tx_state_t : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   START_BIT  : line level during the start bit
//   STOP_BIT   : line level during the stop bit
//   IDLE_LEVEL : line level between frames
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Per-bit cycle counter for the serial transmitter.
// Counts 0..BIT_CYCLES-1 while enabled and raises tick on the last cycle of each
// bit, then wraps to 0. With BIT_CYCLES=1 tick is high on every enabled cycle.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high reset (count -> 0)
//   clear  in   synchronous clear (count -> 0), used while the line is idle
//   en     in   count enable (frame in progress)
//   tick   out  combinational: en && count == BIT_CYCLES-1
module bit_tick_counter #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// stop bit (1); each bit held BIT_CYCLES clocks; line idles high.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   tx_data     in   word to send, sampled only on accept (tx_valid && tx_ready)
//   tx_valid    in   word available
//   tx_ready    out  transmitter idle and able to accept a word
//   serial_out  out  registered serial line, idle = 1
//   busy        out  frame in progress
//   tx_done     out  one-cycle pulse in the cycle after the last stop-bit cycle
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  serial_out_q, serial_out_d;
    logic                  tx_done_q, tx_done_d;

    logic accept;
    logic tick;

    assign accept     = tx_valid && (state_q == IDLE);
    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign serial_out = serial_out_q;
    assign tx_done    = tx_done_q;

    bit_tick_counter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(state_q == IDLE),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = tx_data;
                    parity_d  = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state so the registered output
        // lines up with state_q: the start bit shows in the cycle after accept.
        case (state_d)
            START:   serial_out_d = START_BIT;
            DATA:    serial_out_d = shreg_d[0];
            PARITY:  serial_out_d = parity_d;
            STOP:    serial_out_d = STOP_BIT;
            default: serial_out_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            serial_out_q <= IDLE_LEVEL;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            serial_out_q <= serial_out_d;
            tx_done_q    <= tx_done_d;
        end
    end

endmodule
